// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the weighted voting session controller:
//   - default voter counts, weights, tally width and round window
//   - tally_max(): all-ones value for a tally of a given width
//   - TALLY_MAX: saturation value for the default tally width
//   - vote_state_e: session FSM states
// No ports (package).
// -----------------------------------------------------------------------------
package vote_pkg;

  localparam int unsigned DEF_NP_W        = 32;
  localparam int unsigned DEF_VIP_W       = 8;
  localparam int unsigned DEF_NP_WEIGHT   = 1;
  localparam int unsigned DEF_VIP_WEIGHT  = 4;
  localparam int unsigned DEF_VVIP_WEIGHT = 16;
  localparam int unsigned DEF_TALLY_W     = 8;
  localparam int unsigned DEF_WINDOW      = 16;

  function automatic int unsigned tally_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  localparam int unsigned TALLY_MAX = tally_max(DEF_TALLY_W);

  typedef enum logic [1:0] {
    StIdle,
    StOpen,
    StEval,
    StReport
  } vote_state_e;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// -----------------------------------------------------------------------------
// vote_session_ctrl_if
// Control, voter and status bundle between the system sequencer and the
// voting session controller.
//   master (sequencer): drives start, close, threshold, np, vip, vvip;
//                       observes busy, vote_open, tally, done, pass, round_cnt
//   slave  (controller): the mirror image
// -----------------------------------------------------------------------------
interface vote_session_ctrl_if
  import vote_pkg::*;
#(
  parameter int unsigned NP_W    = DEF_NP_W,
  parameter int unsigned VIP_W   = DEF_VIP_W,
  parameter int unsigned TALLY_W = DEF_TALLY_W
);

  logic               start;
  logic               close;
  logic [TALLY_W-1:0] threshold;
  logic [NP_W-1:0]    np;
  logic [VIP_W-1:0]   vip;
  logic               vvip;

  logic               busy;
  logic               vote_open;
  logic [TALLY_W-1:0] tally;
  logic               done;
  logic               pass;
  logic [7:0]         round_cnt;

  modport master (
    output start, close, threshold, np, vip, vvip,
    input  busy, vote_open, tally, done, pass, round_cnt
  );

  modport slave (
    input  start, close, threshold, np, vip, vvip,
    output busy, vote_open, tally, done, pass, round_cnt
  );

endinterface

// File: rtl/vote_tally.sv
// -----------------------------------------------------------------------------
// vote_tally
// Per-round voted masks, first-vote detection, weighted popcount and a
// saturating tally accumulator.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   i_clear  in   clear masks and tally (new round accepted)
//   i_enable in   count votes this cycle (round open)
//   i_np     in   normal voter levels
//   i_vip    in   VIP voter levels
//   i_vvip   in   VVIP voter level
//   o_tally  out  registered saturating tally
// -----------------------------------------------------------------------------
module vote_tally
  import vote_pkg::*;
#(
  parameter int unsigned NP_W        = DEF_NP_W,
  parameter int unsigned VIP_W       = DEF_VIP_W,
  parameter int unsigned NP_WEIGHT   = DEF_NP_WEIGHT,
  parameter int unsigned VIP_WEIGHT  = DEF_VIP_WEIGHT,
  parameter int unsigned VVIP_WEIGHT = DEF_VVIP_WEIGHT,
  parameter int unsigned TALLY_W     = DEF_TALLY_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [NP_W-1:0]    i_np,
  input  logic [VIP_W-1:0]   i_vip,
  input  logic               i_vvip,
  output logic [TALLY_W-1:0] o_tally
);

  localparam int unsigned SUM_W = TALLY_W + 2;
  localparam logic [SUM_W-1:0] SAT = SUM_W'(tally_max(TALLY_W));

  logic [NP_W-1:0]    r_np_voted;
  logic [VIP_W-1:0]   r_vip_voted;
  logic               r_vvip_voted;
  logic [TALLY_W-1:0] r_tally;

  logic [NP_W-1:0]    w_np_new;
  logic [VIP_W-1:0]   w_vip_new;
  logic               w_vvip_new;
  logic [31:0]        w_inc_raw;
  logic [SUM_W-1:0]   w_inc;
  logic [SUM_W-1:0]   w_sum;

  always_comb begin
    // A voter counts only on its first high level within the round.
    w_np_new   = i_np & ~r_np_voted;
    w_vip_new  = i_vip & ~r_vip_voted;
    w_vvip_new = i_vvip & ~r_vvip_voted;

    w_inc_raw = '0;
    for (int i = 0; i < int'(NP_W); i++) begin
      w_inc_raw = w_inc_raw + (w_np_new[i] ? NP_WEIGHT : 32'd0);
    end
    for (int i = 0; i < int'(VIP_W); i++) begin
      w_inc_raw = w_inc_raw + (w_vip_new[i] ? VIP_WEIGHT : 32'd0);
    end
    w_inc_raw = w_inc_raw + (w_vvip_new ? VVIP_WEIGHT : 32'd0);

    // Any increment at or above the saturation value saturates anyway, so
    // clamp it before the narrow add to keep large weights from wrapping.
    w_inc = (w_inc_raw > 32'(SAT)) ? SAT : w_inc_raw[SUM_W-1:0];
    w_sum = {2'b00, r_tally} + w_inc;
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_np_voted   <= '0;
      r_vip_voted  <= '0;
      r_vvip_voted <= 1'b0;
      r_tally      <= '0;
    end else if (i_enable) begin
      r_np_voted   <= r_np_voted | i_np;
      r_vip_voted  <= r_vip_voted | i_vip;
      r_vvip_voted <= r_vvip_voted | i_vvip;
      r_tally      <= (w_sum > SAT) ? SAT[TALLY_W-1:0] : w_sum[TALLY_W-1:0];
    end
  end

  assign o_tally = r_tally;

endmodule

// File: rtl/vote_session_ctrl.sv
// -----------------------------------------------------------------------------
// vote_session_ctrl
// Voting round controller: opens a round on start, keeps it open for at most
// WINDOW cycles (or until close), evaluates the tally against the threshold
// latched at start, then pulses done for one cycle with the pass result.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset (discards any round in flight)
//   bus    slave modport of vote_session_ctrl_if:
//            start/close/threshold  sequencer controls
//            np/vip/vvip            raw voter levels
//            busy/vote_open/done    session status
//            tally/pass/round_cnt   round results
// -----------------------------------------------------------------------------
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NP_W        = DEF_NP_W,
  parameter int unsigned VIP_W       = DEF_VIP_W,
  parameter int unsigned NP_WEIGHT   = DEF_NP_WEIGHT,
  parameter int unsigned VIP_WEIGHT  = DEF_VIP_WEIGHT,
  parameter int unsigned VVIP_WEIGHT = DEF_VVIP_WEIGHT,
  parameter int unsigned TALLY_W     = DEF_TALLY_W,
  parameter int unsigned WINDOW      = DEF_WINDOW
) (
  input  logic               clk,
  input  logic               reset,
  vote_session_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WINDOW - 1);

  vote_state_e        r_state;
  vote_state_e        w_state_next;
  logic [TIMER_W-1:0] r_timer;
  logic [TALLY_W-1:0] r_threshold;
  logic               r_pass;
  logic [7:0]         r_round_cnt;

  logic               w_accept_start;
  logic               w_tally_clear;
  logic               w_tally_enable;
  logic [TALLY_W-1:0] w_tally;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (bus.start) w_state_next = StOpen;
      StOpen:   if (bus.close || (r_timer == '0)) w_state_next = StEval;
      StEval:   w_state_next = StReport;
      StReport: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Outputs and datapath controls decoded from the current state.
  always_comb begin
    w_accept_start = (r_state == StIdle) && bus.start;
    w_tally_clear  = w_accept_start;
    w_tally_enable = (r_state == StOpen);
    bus.busy       = (r_state != StIdle);
    bus.vote_open  = (r_state == StOpen);
    bus.done       = (r_state == StReport);
    bus.tally      = w_tally;
    bus.pass       = r_pass;
    bus.round_cnt  = r_round_cnt;
  end

  // Timer, threshold latch and round results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer     <= '0;
      r_threshold <= '0;
      r_pass      <= 1'b0;
      r_round_cnt <= '0;
    end else begin
      if (w_accept_start) begin
        r_timer     <= TIMER_LOAD;
        r_threshold <= bus.threshold;
        r_pass      <= 1'b0;
      end else if ((r_state == StOpen) && (r_timer != '0)) begin
        r_timer <= r_timer - TIMER_W'(1);
      end
      // Loaded on the edge into REPORT so pass and round_cnt line up with done.
      if (r_state == StEval) begin
        r_pass      <= (w_tally >= r_threshold);
        r_round_cnt <= r_round_cnt + 8'd1;
      end
    end
  end

  vote_tally #(
    .NP_W        (NP_W),
    .VIP_W       (VIP_W),
    .NP_WEIGHT   (NP_WEIGHT),
    .VIP_WEIGHT  (VIP_WEIGHT),
    .VVIP_WEIGHT (VVIP_WEIGHT),
    .TALLY_W     (TALLY_W)
  ) u_tally (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_tally_clear),
    .i_enable (w_tally_enable),
    .i_np     (bus.np),
    .i_vip    (bus.vip),
    .i_vvip   (bus.vvip),
    .o_tally  (w_tally)
  );

endmodule

// File: tb/tb_vote_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vote_session_ctrl
// Randomized scoreboard bench for vote_session_ctrl with a set-based
// reference model; a second instance uses NP_WEIGHT=8 for saturation.
// -----------------------------------------------------------------------------
module tb_vote_session_ctrl;
  import vote_pkg::*;

  localparam int NP_W   = 32;
  localparam int VIP_W  = 8;
  localparam int WINDOW = 16;
  localparam int TMAX   = 255;

  logic clk;
  logic reset;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vote_session_ctrl_if bus ();
  vote_session_ctrl_if bus8 ();

  vote_session_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vote_session_ctrl #(
    .NP_WEIGHT (8)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int tally;
    int pass;
    int rounds;
    int done_cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model: who has voted this round, and the running tally.
  bit m_np[NP_W];
  bit m_vip[VIP_W];
  bit m_vvip;
  int m_tally;
  int m_rounds;
  int last_pass;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic void model_clear();
    foreach (m_np[i]) m_np[i] = 1'b0;
    foreach (m_vip[i]) m_vip[i] = 1'b0;
    m_vvip  = 1'b0;
    m_tally = 0;
  endfunction

  function automatic void model_vote(input logic [NP_W-1:0] np, input logic [VIP_W-1:0] vip,
                                     input logic vvip);
    int inc = 0;
    for (int i = 0; i < NP_W; i++) if (np[i] && !m_np[i]) begin inc += 1; m_np[i] = 1'b1; end
    for (int i = 0; i < VIP_W; i++) if (vip[i] && !m_vip[i]) begin inc += 4; m_vip[i] = 1'b1; end
    if (vvip && !m_vvip) begin inc += 16; m_vvip = 1'b1; end
    m_tally = (m_tally + inc > TMAX) ? TMAX : m_tally + inc;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected round.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL done_unexpected: got done=1 expected no round pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_tally", bus.tally, e.tally);
        chk("done_pass", bus.pass, e.pass);
        chk("done_round_cnt", bus.round_cnt, e.rounds);
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic rand_levels();
    bus.np   = $urandom & $urandom & $urandom;
    bus.vip  = 8'($urandom & $urandom);
    bus.vvip = ($urandom_range(0, 7) == 0);
  endtask

  // mode 0: sparse random, 1: all high in cycle 1, 2: duplicate pattern,
  // 3: basic (np=0xF, vip=0x3 in cycle 1). close_k=0 means run the full window.
  task automatic do_round(input int thr, input int close_k, input int mode, input bit noise);
    int len;
    int s;
    logic [NP_W-1:0]  np;
    logic [VIP_W-1:0] vip;
    logic             vvip;
    exp_t e;
    bus.start     = 1'b1;
    bus.close     = 1'b0;
    bus.threshold = 8'(thr);
    @(posedge clk); #1;
    s = cyc;
    model_clear();
    last_pass = 0;
    chk("pass_cleared", bus.pass, 0);
    len = (close_k > 0) ? close_k : WINDOW;
    for (int k = 1; k <= len; k++) begin
      np = '0; vip = '0; vvip = 1'b0;
      case (mode)
        1: if (k == 1) begin np = '1; vip = '1; vvip = 1'b1; end
           else begin np = $urandom & $urandom; vip = 8'($urandom); vvip = 1'($urandom); end
        2: begin np = (k <= 10) ? 32'h1 : 32'h0; vvip = (k == 2 || k == 4 || k == 6); end
        3: if (k == 1) begin np = 32'h0000_000F; vip = 8'h03; end
        default: begin
          np = $urandom & $urandom & $urandom; vip = 8'($urandom & $urandom);
          vvip = ($urandom_range(0, 7) == 0);
        end
      endcase
      bus.np = np; bus.vip = vip; bus.vvip = vvip;
      bus.close = (k == close_k);
      if (noise) begin bus.start = 1'($urandom); bus.threshold = 8'h00; end
      else bus.start = 1'b0;
      chk("open_vote_open", bus.vote_open, 1);
      chk("open_tally", bus.tally, m_tally);
      model_vote(np, vip, vvip);
      @(posedge clk); #1;
    end
    // EVAL: inputs and start must be ignored from here on.
    bus.close = 1'b0;
    bus.start = noise;
    bus.threshold = 8'h00;
    rand_levels();
    chk("eval_vote_open", bus.vote_open, 0);
    chk("eval_busy", bus.busy, 1);
    chk("eval_tally", bus.tally, m_tally);
    m_rounds    = (m_rounds + 1) % 256;
    e.tally     = m_tally;
    e.pass      = (m_tally >= thr) ? 1 : 0;
    e.rounds    = m_rounds;
    e.done_cyc  = s + len + 1;
    sb.push_back(e);
    last_pass   = e.pass;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("after_done_busy", bus.busy, 0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.close = 1'($urandom);
      rand_levels();
      @(posedge clk); #1;
      chk("idle_busy", bus.busy, 0);
      chk("idle_pass_held", bus.pass, last_pass);
      chk("idle_tally_held", bus.tally, m_tally);
    end
    bus.close = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat8;
    int seen;
    bus.start = 0; bus.close = 0; bus.threshold = 0; bus.np = 0; bus.vip = 0; bus.vvip = 0;
    bus8.start = 0; bus8.close = 0; bus8.threshold = 0; bus8.np = 0; bus8.vip = 0; bus8.vvip = 0;
    m_rounds = 0; last_pass = 0;
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_vote_open", bus.vote_open, 0);
    chk("rst_tally", bus.tally, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_round_cnt", bus.round_cnt, 0);
    reset = 1'b0;

    idle_gap(3);

    // Reset in OPEN cycle 5 with 36 already tallied.
    bus.start = 1'b1; bus.threshold = 8'd50;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_clear();
    for (int k = 1; k <= 4; k++) begin
      bus.np   = (k == 2) ? 32'hF : 32'h0;
      bus.vip  = (k == 1) ? 8'h0F : 8'h00;
      bus.vvip = (k == 1);
      model_vote(bus.np, bus.vip, bus.vvip);
      @(posedge clk); #1;
    end
    chk("rst_mid_tally_before", bus.tally, m_tally);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    m_rounds = 0;
    chk("rst_mid_tally", bus.tally, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_round_cnt", bus.round_cnt, 0);

    do_round(20, 0, 3, 1'b0);   // basic: 12, fail, round 1, done at cycle 18
    do_round(17, 0, 2, 1'b0);   // duplicate suppression: 17, equality passes
    idle_gap(2);
    do_round(int'($urandom_range(0, 60)), 3, 0, 1'b0);  // early close
    do_round(200, 0, 0, 1'b1);  // start + threshold=0 during round ignored
    for (int r = 0; r < 4; r++) do_round(int'($urandom_range(60, 100)), 0, 1, 1'b0);
    for (int r = 0; r < 20; r++) begin
      do_round(int'($urandom_range(0, 120)),
               ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, WINDOW)),
               int'($urandom_range(0, 1)), 1'($urandom));
      idle_gap(int'($urandom_range(0, 3)));
    end

    // NP_WEIGHT=8 instance: first-cycle increment alone exceeds the maximum.
    sat8 = 32 * 8 + 8 * 4 + 16;
    if (sat8 > TMAX) sat8 = TMAX;
    bus8.threshold = 8'd255; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.np = '1; bus8.vip = '1; bus8.vvip = 1'b1;
    @(posedge clk); #1;
    chk("sat8_first_cycle", bus8.tally, sat8);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      if (bus8.done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("sat8_done_seen", seen, 1);
    chk("sat8_done_tally", bus8.tally, sat8);
    chk("sat8_pass", bus8.pass, (sat8 >= 255) ? 1 : 0);
    bus8.np = '0; bus8.vip = '0; bus8.vvip = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
